alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 27 ++
 rtl/operand_fwd_mux.sv | 48 ++++
 rtl/alu_issue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice: op codes, skid-buffer states
// and a small op-class helper.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

  // Shift ops only look at the low 5 bits of operand B.
  function automatic logic is_shift(logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one ALU source operand: register data (optionally forwarded from
// EX/WB) or an alternate source (pc / immediate). Register x0 always reads 0.
// Forwarding is compiled in only when ALU_ISSUE_FWD_EN is defined.
module operand_fwd_mux
  import alu_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned RegIdxWidth = 5
) (
  input  logic                   sel_alt_i,
  input  logic [RegIdxWidth-1:0] idx_i,
  input  logic [DataWidth-1:0]   reg_data_i,
  input  logic [DataWidth-1:0]   alt_data_i,
  input  logic                   fwd_ex_valid_i,
  input  logic [RegIdxWidth-1:0] fwd_ex_rd_i,
  input  logic [DataWidth-1:0]   fwd_ex_data_i,
  input  logic                   fwd_wb_valid_i,
  input  logic [RegIdxWidth-1:0] fwd_wb_rd_i,
  input  logic [DataWidth-1:0]   fwd_wb_data_i,
  output logic [DataWidth-1:0]   operand_o
);

  logic [DataWidth-1:0] reg_val;

`ifndef ALU_ISSUE_FWD_EN
  // Forwarding ports exist but are not consumed in this build.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_valid_i, fwd_ex_rd_i, fwd_ex_data_i,
                        fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i};
`endif

  // Pick register value (EX beats WB), force x0 to zero, then apply source select.
  always_comb begin
    reg_val = reg_data_i;
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_ex_valid_i && (fwd_ex_rd_i == idx_i)) begin
      reg_val = fwd_ex_data_i;
    end else if (fwd_wb_valid_i && (fwd_wb_rd_i == idx_i)) begin
      reg_val = fwd_wb_data_i;
    end
`endif
    if (idx_i == '0) begin
      reg_val = '0;
    end
    operand_o = sel_alt_i ? alt_data_i : reg_val;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: 2-entry skid buffer holding fully resolved ALU operands.
// Operands are captured at acceptance and never re-forwarded afterwards.
// Optional build macro: ALU_ISSUE_FWD_EN enables EX/WB operand forwarding.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned RegIdxWidth = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2:0]             op_i,
  input  logic                   srcA_sel_i,
  input  logic                   srcB_sel_i,
  input  logic [RegIdxWidth-1:0] rs1_idx_i,
  input  logic [RegIdxWidth-1:0] rs2_idx_i,
  input  logic [DataWidth-1:0]   rs1_data_i,
  input  logic [DataWidth-1:0]   rs2_data_i,
  input  logic [DataWidth-1:0]   imm_i,
  input  logic [DataWidth-1:0]   pc_i,
  input  logic [RegIdxWidth-1:0] rd_i,
  input  logic                   fwd_ex_valid_i,
  input  logic                   fwd_wb_valid_i,
  input  logic [RegIdxWidth-1:0] fwd_ex_rd_i,
  input  logic [RegIdxWidth-1:0] fwd_wb_rd_i,
  input  logic [DataWidth-1:0]   fwd_ex_data_i,
  input  logic [DataWidth-1:0]   fwd_wb_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2:0]             ALUControl_o,
  output logic [DataWidth-1:0]   srcA_o,
  output logic [DataWidth-1:0]   srcB_o,
  output logic [RegIdxWidth-1:0] rd_o
);

  // Entry layout: {op, srcA, srcB, rd}
  localparam int unsigned EntryW = 3 + 2 * DataWidth + RegIdxWidth;

  skid_state_e          state_q;
  logic [EntryW-1:0]    head_q, skid_q, new_entry;
  logic [DataWidth-1:0] opa_new, opb_raw, opb_new;
  logic                 push, pop;

  operand_fwd_mux #(
    .DataWidth  (DataWidth),
    .RegIdxWidth(RegIdxWidth)
  ) u_src_a (
    .sel_alt_i     (srcA_sel_i),
    .idx_i         (rs1_idx_i),
    .reg_data_i    (rs1_data_i),
    .alt_data_i    (pc_i),
    .fwd_ex_valid_i(fwd_ex_valid_i),
    .fwd_ex_rd_i   (fwd_ex_rd_i),
    .fwd_ex_data_i (fwd_ex_data_i),
    .fwd_wb_valid_i(fwd_wb_valid_i),
    .fwd_wb_rd_i   (fwd_wb_rd_i),
    .fwd_wb_data_i (fwd_wb_data_i),
    .operand_o     (opa_new)
  );

  operand_fwd_mux #(
    .DataWidth  (DataWidth),
    .RegIdxWidth(RegIdxWidth)
  ) u_src_b (
    .sel_alt_i     (srcB_sel_i),
    .idx_i         (rs2_idx_i),
    .reg_data_i    (rs2_data_i),
    .alt_data_i    (imm_i),
    .fwd_ex_valid_i(fwd_ex_valid_i),
    .fwd_ex_rd_i   (fwd_ex_rd_i),
    .fwd_ex_data_i (fwd_ex_data_i),
    .fwd_wb_valid_i(fwd_wb_valid_i),
    .fwd_wb_rd_i   (fwd_wb_rd_i),
    .fwd_wb_data_i (fwd_wb_data_i),
    .operand_o     (opb_raw)
  );

  // Mask shift amount and pack the incoming entry.
  always_comb begin
    opb_new   = is_shift(op_i) ? {{(DataWidth - 5){1'b0}}, opb_raw[4:0]} : opb_raw;
    new_entry = {op_i, opa_new, opb_new, rd_i};
  end

  // Handshake flags decoded from registered state only.
  always_comb begin
    in_ready_o  = (state_q != StTwo);
    out_valid_o = (state_q != StEmpty);
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;
  end

  assign {ALUControl_o, srcA_o, srcB_o, rd_o} = head_q;

  // Skid buffer control; flush wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            head_q  <= new_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_q <= new_entry;
          end else if (push) begin
            skid_q  <= new_entry;
            state_q <= StTwo;
          end else if (pop) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule
